// File: rtl/alu_share_arbiter.sv
// Two-requester arbiter in front of a single shared 8-bit ALU.
// Each requester hands over one operation at a time. The shared ALU computes
// it and holds the 9-bit result until the consumer takes it. Only one operation
// is in flight at any time, and there is no result buffering.
module alu_share_arbiter #(
    parameter int FIXED_PRIO = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [7:0]  req0_a,
    input  logic [7:0]  req0_b,
    input  logic [1:0]  req0_op,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [7:0]  req1_a,
    input  logic [7:0]  req1_b,
    input  logic [1:0]  req1_op,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [8:0]  rsp_data,
    output logic        rsp_id,
    output logic [15:0] ops_done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_nextState;

    logic        w_grantId;
    logic        w_accept;
    logic        w_rspFire;
    logic        r_lastGrant;

    logic [7:0]  r_opA;
    logic [7:0]  r_opB;
    logic [1:0]  r_op;
    logic        r_opId;

    logic [8:0]  w_result;
    logic [8:0]  r_rspData;
    logic        r_rspId;
    logic [15:0] r_opsDone;

    // Pick a winner. With both requesters valid, round-robin favours the one
    // that did not own the last completed response. Fixed mode always favours req0.
    always_comb begin
        w_grantId = 1'b0;
        if (req0_valid && req1_valid) begin
            if (FIXED_PRIO != 0) begin
                w_grantId = 1'b0;
            end else begin
                w_grantId = ~r_lastGrant;
            end
        end else if (req1_valid) begin
            w_grantId = 1'b1;
        end
    end

    assign w_accept  = (r_state == IDLE) && (req0_valid || req1_valid) && !rst;
    assign w_rspFire = (r_state == RESP) && rsp_ready;

    // State register. Reset drops any operation that is in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic and handshake outputs. Ready is shown only in IDLE, and only for the winner.
    always_comb begin
        w_nextState = r_state;
        req0_ready  = 1'b0;
        req1_ready  = 1'b0;
        rsp_valid   = 1'b0;
        case (r_state)
            IDLE: begin
                if (!rst) begin
                    req0_ready = req0_valid && !w_grantId;
                    req1_ready = req1_valid && w_grantId;
                end
                if (req0_valid || req1_valid) begin
                    w_nextState = EXEC;
                end
            end
            EXEC: begin
                w_nextState = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    w_nextState = IDLE;
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // Capture the winner's operands on the accept edge. Other changes to the operand inputs are ignored.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_opA  <= 8'h00;
            r_opB  <= 8'h00;
            r_op   <= 2'b00;
            r_opId <= 1'b0;
        end else if (w_accept) begin
            r_opA  <= w_grantId ? req1_a  : req0_a;
            r_opB  <= w_grantId ? req1_b  : req0_b;
            r_op   <= w_grantId ? req1_op : req0_op;
            r_opId <= w_grantId;
        end
    end

    // The shared ALU. Bit 8 carries the add carry or the subtract borrow.
    always_comb begin
        w_result = 9'h000;
        case (r_op)
            2'b00:   w_result = {1'b0, r_opA} + {1'b0, r_opB};
            2'b01:   w_result = {1'b0, r_opA} - {1'b0, r_opB};
            2'b10:   w_result = {1'b0, r_opA ^ r_opB};
            default: w_result = {1'b0, r_opA[6:0], 1'b0};
        endcase
    end

    // Register the result in EXEC. It then stays put while the consumer stalls in RESP.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rspData <= 9'h000;
            r_rspId   <= 1'b0;
        end else if (r_state == EXEC) begin
            r_rspData <= w_result;
            r_rspId   <= r_opId;
        end
    end

    // Completion bookkeeping: count responses and remember the owner for round-robin.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_opsDone   <= 16'h0000;
            r_lastGrant <= 1'b1;
        end else if (w_rspFire) begin
            r_opsDone   <= r_opsDone + 16'd1;
            r_lastGrant <= r_rspId;
        end
    end

    assign rsp_data = r_rspData;
    assign rsp_id   = r_rspId;
    assign ops_done = r_opsDone;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Testbench for alu_share_arbiter. It runs directed vectors, randomized
// transactions against a transaction-level model, and corner-case sequences.
module tb_alu_share_arbiter;

    logic        clk;
    logic        rst;
    logic        req0Valid, req1Valid, rspReady;
    logic        req0Ready, req1Ready, rspValid, rspId;
    logic [7:0]  req0A, req0B, req1A, req1B;
    logic [1:0]  req0Op, req1Op;
    logic [8:0]  rspData;
    logic [15:0] opsDone;

    logic        fReq0Valid, fReq1Valid, fRspReady;
    logic        fReq0Ready, fReq1Ready, fRspValid, fRspId;
    logic [8:0]  fRspData;
    logic [15:0] fOpsDone;

    int testsRun  = 0;
    int failCount = 0;
    int modelLast = 1;
    int modelOps  = 0;

    typedef struct {
        logic       v0;
        logic [7:0] a0;
        logic [7:0] b0;
        logic [1:0] op0;
        logic       v1;
        logic [7:0] a1;
        logic [7:0] b1;
        logic [1:0] op1;
        logic [8:0] expData;
        logic       expId;
    } vec_t;

    vec_t vecs[8];

    alu_share_arbiter #(.FIXED_PRIO(0)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0Valid), .req0_ready(req0Ready),
        .req0_a(req0A), .req0_b(req0B), .req0_op(req0Op),
        .req1_valid(req1Valid), .req1_ready(req1Ready),
        .req1_a(req1A), .req1_b(req1B), .req1_op(req1Op),
        .rsp_valid(rspValid), .rsp_ready(rspReady),
        .rsp_data(rspData), .rsp_id(rspId), .ops_done(opsDone)
    );

    alu_share_arbiter #(.FIXED_PRIO(1)) dutFixed (
        .clk(clk), .rst(rst),
        .req0_valid(fReq0Valid), .req0_ready(fReq0Ready),
        .req0_a(8'h01), .req0_b(8'h02), .req0_op(2'b00),
        .req1_valid(fReq1Valid), .req1_ready(fReq1Ready),
        .req1_a(8'h10), .req1_b(8'h20), .req1_op(2'b00),
        .rsp_valid(fRspValid), .rsp_ready(fRspReady),
        .rsp_data(fRspData), .rsp_id(fRspId), .ops_done(fOpsDone)
    );

    // Free-running clock, 10 ns period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference ALU computed with plain integer arithmetic.
    function automatic int refResult(input int a, input int b, input int op);
        case (op)
            0:       return a + b;
            1:       return (a - b + 512) % 512;
            2:       return a ^ b;
            default: return (a * 2) % 256;
        endcase
    endfunction

    // Reference round-robin arbitration: the winner is the requester that did not own the last response.
    function automatic int refGrant(input int v0, input int v1);
        if (v0 != 0 && v1 != 0) return 1 - modelLast;
        if (v0 != 0) return 0;
        return 1;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic v0, input logic [7:0] a0, input logic [7:0] b0, input logic [1:0] op0,
                                 input logic v1, input logic [7:0] a1, input logic [7:0] b1, input logic [1:0] op1);
        req0Valid = v0; req0A = a0; req0B = b0; req0Op = op0;
        req1Valid = v1; req1A = a1; req1B = b1; req1Op = op1;
    endtask

    task automatic scrambleInputs();
        applyStimulus(1'($urandom), 8'($urandom), 8'($urandom), 2'($urandom),
                      1'($urandom), 8'($urandom), 8'($urandom), 2'($urandom));
    endtask

    // One full transaction. It starts just after an edge with the DUT in IDLE,
    // and it ends just after the response handshake edge.
    task automatic doTransaction(input vec_t v, input int stall, input string tag);
        applyStimulus(v.v0, v.a0, v.b0, v.op0, v.v1, v.a1, v.b1, v.op1);
        rspReady = 1'($urandom);
        #1;
        checkOutput({tag, " ready0"}, 32'(req0Ready), 32'(v.expId == 1'b0));
        checkOutput({tag, " ready1"}, 32'(req1Ready), 32'(v.expId == 1'b1));
        @(posedge clk); #1;
        scrambleInputs();
        rspReady = 1'($urandom);
        #1;
        checkOutput({tag, " execValid"}, 32'(rspValid), 32'd0);
        checkOutput({tag, " execReady"}, 32'(req0Ready | req1Ready), 32'd0);
        @(posedge clk); #1;
        scrambleInputs();
        rspReady = (stall == 0);
        #1;
        checkOutput({tag, " rspValid"}, 32'(rspValid), 32'd1);
        checkOutput({tag, " rspData"}, 32'(rspData), 32'(v.expData));
        checkOutput({tag, " rspId"}, 32'(rspId), 32'(v.expId));
        checkOutput({tag, " respReady"}, 32'(req0Ready | req1Ready), 32'd0);
        for (int s = 1; s <= stall; s++) begin
            @(posedge clk); #1;
            scrambleInputs();
            #1;
            checkOutput({tag, " stallValid"}, 32'(rspValid), 32'd1);
            checkOutput({tag, " stallData"}, 32'(rspData), 32'(v.expData));
            checkOutput({tag, " stallId"}, 32'(rspId), 32'(v.expId));
            checkOutput({tag, " stallReady"}, 32'(req0Ready | req1Ready), 32'd0);
            rspReady = (s == stall);
        end
        @(posedge clk); #1;
        applyStimulus(1'b0, 8'h00, 8'h00, 2'b00, 1'b0, 8'h00, 8'h00, 2'b00);
        rspReady = 1'($urandom);
        modelLast = int'(v.expId);
        modelOps  = (modelOps + 1) % 65536;
        #1;
        checkOutput({tag, " doneValid"}, 32'(rspValid), 32'd0);
        checkOutput({tag, " opsDone"}, 32'(opsDone), 32'(modelOps));
    endtask

    // Main test sequence.
    initial begin
        vec_t rv;
        int   fixedSeen;
        rst = 1'b1;
        rspReady = 1'b0;
        fReq0Valid = 1'b0; fReq1Valid = 1'b0; fRspReady = 1'b0;
        applyStimulus(1'b1, 8'h11, 8'h22, 2'b00, 1'b1, 8'h33, 8'h44, 2'b01);

        vecs[0] = '{1'b1, 8'hFF, 8'h01, 2'b00, 1'b0, 8'h00, 8'h00, 2'b00, 9'h100, 1'b0};
        vecs[1] = '{1'b0, 8'h00, 8'h00, 2'b00, 1'b1, 8'h05, 8'h07, 2'b01, 9'h1FE, 1'b1};
        vecs[2] = '{1'b0, 8'h00, 8'h00, 2'b00, 1'b1, 8'hF0, 8'hFF, 2'b10, 9'h00F, 1'b1};
        vecs[3] = '{1'b0, 8'h00, 8'h00, 2'b00, 1'b1, 8'h81, 8'h00, 2'b11, 9'h002, 1'b1};
        vecs[4] = '{1'b1, 8'h12, 8'h34, 2'b00, 1'b1, 8'h99, 8'h99, 2'b01, 9'h046, 1'b0};
        vecs[5] = '{1'b1, 8'h01, 8'h01, 2'b11, 1'b1, 8'h80, 8'h80, 2'b00, 9'h100, 1'b1};
        vecs[6] = '{1'b1, 8'h00, 8'h01, 2'b01, 1'b1, 8'h01, 8'h01, 2'b10, 9'h1FF, 1'b0};
        vecs[7] = '{1'b1, 8'h0F, 8'h0F, 2'b00, 1'b1, 8'hAA, 8'h55, 2'b10, 9'h0FF, 1'b1};

        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset ready0", 32'(req0Ready), 32'd0);
        checkOutput("reset ready1", 32'(req1Ready), 32'd0);
        checkOutput("reset rspValid", 32'(rspValid), 32'd0);
        checkOutput("reset rspData", 32'(rspData), 32'd0);
        checkOutput("reset rspId", 32'(rspId), 32'd0);
        checkOutput("reset opsDone", 32'(opsDone), 32'd0);
        applyStimulus(1'b0, 8'h00, 8'h00, 2'b00, 1'b0, 8'h00, 8'h00, 2'b00);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed vectors: the opcode examples, then alternating round-robin grants.
        for (int i = 0; i < 8; i++) begin
            doTransaction(vecs[i], (i == 2) ? 5 : (i % 3), $sformatf("vec%0d", i));
        end

        // An idle cycle with no valid requester must not start anything.
        @(posedge clk); #1;
        checkOutput("idle ready", 32'(req0Ready | req1Ready), 32'd0);
        checkOutput("idle rspValid", 32'(rspValid), 32'd0);

        // Randomized transactions checked against the transaction-level model.
        for (int i = 0; i < 40; i++) begin
            rv.v0 = 1'($urandom); rv.v1 = 1'($urandom);
            rv.a0 = 8'($urandom); rv.b0 = 8'($urandom); rv.op0 = 2'($urandom);
            rv.a1 = 8'($urandom); rv.b1 = 8'($urandom); rv.op1 = 2'($urandom);
            if (!rv.v0 && !rv.v1) begin
                applyStimulus(1'b0, rv.a0, rv.b0, rv.op0, 1'b0, rv.a1, rv.b1, rv.op1);
                @(posedge clk); #1;
                checkOutput("randIdle rspValid", 32'(rspValid), 32'd0);
                continue;
            end
            rv.expId = 1'(refGrant(int'(rv.v0), int'(rv.v1)));
            if (rv.expId) rv.expData = 9'(refResult(int'(rv.a1), int'(rv.b1), int'(rv.op1)));
            else          rv.expData = 9'(refResult(int'(rv.a0), int'(rv.b0), int'(rv.op0)));
            doTransaction(rv, int'($urandom_range(0, 3)), $sformatf("rand%0d", i));
        end

        // Reset while a response is pending drops it with no count and favours req0 again.
        applyStimulus(1'b0, 8'h00, 8'h00, 2'b00, 1'b1, 8'h03, 8'h04, 2'b00);
        rspReady = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        checkOutput("preReset rspValid", 32'(rspValid), 32'd1);
        applyStimulus(1'b1, 8'h00, 8'h00, 2'b00, 1'b1, 8'h00, 8'h00, 2'b00);
        rst = 1'b1;
        #1;
        checkOutput("midReset rspValid", 32'(rspValid), 32'd0);
        checkOutput("midReset ready", 32'(req0Ready | req1Ready), 32'd0);
        checkOutput("midReset opsDone", 32'(opsDone), 32'd0);
        checkOutput("midReset rspData", 32'(rspData), 32'd0);
        modelLast = 1;
        modelOps  = 0;
        applyStimulus(1'b0, 8'h00, 8'h00, 2'b00, 1'b0, 8'h00, 8'h00, 2'b00);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        rv = '{1'b1, 8'h20, 8'h22, 2'b10, 1'b1, 8'h01, 8'h01, 2'b00, 9'h002, 1'b0};
        doTransaction(rv, 1, "postReset");

        // Counter wrap: preload the counter just below rollover.
        force dut.r_opsDone = 16'hFFFF;
        #1;
        release dut.r_opsDone;
        #1;
        checkOutput("preload opsDone", 32'(opsDone), 32'hFFFF);
        modelOps = 65535;
        rv = '{1'b1, 8'h7F, 8'h01, 2'b00, 1'b0, 8'h00, 8'h00, 2'b00, 9'h080, 1'b0};
        doTransaction(rv, 0, "wrap");

        // Fixed priority: with both requesters valid, req0 wins every time.
        fReq0Valid = 1'b1; fReq1Valid = 1'b1; fRspReady = 1'b1;
        fixedSeen = 0;
        for (int c = 0; c < 30 && fixedSeen < 3; c++) begin
            @(negedge clk);
            if (fRspValid && fRspReady) begin
                fixedSeen++;
                checkOutput("fixed rspId", 32'(fRspId), 32'd0);
                checkOutput("fixed rspData", 32'(fRspData), 32'h003);
            end
        end
        checkOutput("fixed responses", 32'(fixedSeen), 32'd3);
        fReq0Valid = 1'b0; fReq1Valid = 1'b0;

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule

// File: doc/alu_share_arbiter.md
ALU_SHARE_ARBITER -- requirements
Module: alu_share_arbiter

Interface
REQ-001 Parameter FIXED_PRIO, default 0, meaning 0 = round-robin arbitration, 1 = requester 0 always wins.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 req0_valid  input  1  requester 0 has an operation pending.
REQ-005 req0_ready  output  1  requester 0 operation accepted this cycle.
REQ-006 req0_a, req0_b  input  8 each  requester 0 operands.
REQ-007 req0_op  input  2  requester 0 opcode.
REQ-008 req1_valid, req1_ready, req1_a, req1_b, req1_op  same widths and meaning as REQ-004..007, for requester 1.
REQ-009 rsp_valid  output  1  result available.
REQ-010 rsp_ready  input  1  consumer takes the result.
REQ-011 rsp_data  output  9  result.
REQ-012 rsp_id  output  1  index of the requester that owns rsp_data.
REQ-013 ops_done  output  16  count of completed responses.

Function
REQ-014 The FSM SHALL have three states: IDLE, EXEC, RESP.
REQ-015 In IDLE, reqN_ready SHALL be high combinationally only for the granted requester; it SHALL be low in EXEC and RESP.
REQ-016 Grant in IDLE SHALL be: one valid -> that one; both valid -> FIXED_PRIO=1: req0; FIXED_PRIO=0: the requester not granted most recently (req0 after reset).
REQ-017 On a valid&ready edge, the block SHALL latch A, B, op and id and move IDLE->EXEC; with no valid it SHALL stay in IDLE.
REQ-018 In EXEC, the block SHALL register the result into rsp_data and rsp_id, then move to RESP on the next edge.
REQ-019 Opcode 00 SHALL give A+B zero-extended to 9 bits, with bit 8 = carry.
REQ-020 Opcode 01 SHALL give (A-B) mod 512 on 9 bits, with bit 8 = borrow.
REQ-021 Opcode 10 SHALL give {0, A^B}.
REQ-022 Opcode 11 SHALL give {0, A[6:0], 0}; A[7] is discarded.
REQ-023 In RESP, rsp_valid SHALL be high and rsp_data/rsp_id SHALL be stable until rsp_ready.
REQ-024 On rsp_valid&rsp_ready, the block SHALL go to IDLE, increment ops_done and record rsp_id as last granted.
REQ-025 Latency: accept at edge T -> rsp_valid high after edge T+1; earliest next accept at the edge after the response handshake.
REQ-026 Throughput SHALL be at most one operation per 3 cycles; there is no response buffering.
REQ-027 ops_done SHALL wrap 0xFFFF->0x0000 without a flag.
REQ-028 A requester dropping valid while not granted SHALL have no effect; requester operands are ignored outside the accept cycle.
REQ-029 rsp_ready asserted while rsp_valid is low SHALL be ignored.

Reset
REQ-030 While rst is high, state SHALL be IDLE and both reqN_ready SHALL be low.
REQ-031 While rst is high, rsp_valid=0, rsp_data=0, rsp_id=0, ops_done=0 and the round-robin pointer SHALL favour req0.
REQ-032 Reset asserted in EXEC or RESP SHALL abort the operation with no response and no ops_done increment.
REQ-033 Operation SHALL resume on the first edge after rst deasserts.

Verification
REQ-034 req0 op=00 A=0xFF B=0x01, rsp_ready=1 -> rsp_data=0x100, rsp_id=0, rsp_valid after 2 edges, ops_done=1.
REQ-035 req1 op=01 A=0x05 B=0x07 -> rsp_data=0x1FE, rsp_id=1; op=10 A=0xF0 B=0xFF -> 0x00F; op=11 A=0x81 -> 0x002.
REQ-036 Both valid continuously, FIXED_PRIO=0 -> grants 0,1,0,1; with FIXED_PRIO=1 -> grants 0,0,0.
REQ-037 rsp_ready held low 5 cycles -> rsp_valid and rsp_data stable, both readys low, no new accept until handshake.
REQ-038 rst pulsed in RESP -> rsp_valid=0 immediately, ops_done unchanged at its pre-reset value 0, next grant to req0.
REQ-039 Preload ops_done to 0xFFFF via 65535 ops (or force) plus one op -> ops_done=0x0000.
